imuldiv_int_div_issue: RTL and testbench
========================================

# imuldiv_int_div_issue

Requester-side front end for the iterative integer divider. It accepts one RISC-V M-extension divide/remainder operation at a time from the execute stage and drives the divider's `divreq` val/rdy request channel. It consumes the 64-bit `divresp` message (remainder in [63:32], quotient in [31:0]), selects the half the operation needs, and presents it with its destination tag on a writeback val/rdy channel.

## Interface
Parameters:
- `TAG_W`, 5: width of the destination-register tag carried through.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_val`  in  1  upstream operation valid.
- `op_rdy`  out  1  block can accept an operation.
- `op_fn`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `op_a`  in  32  dividend.
- `op_b`  in  32  divisor.
- `op_tag`  in  TAG_W  destination tag.
- `divreq_msg_fn`  out  1  1 signed, 0 unsigned, driven as `~fn_reg[0]`.
- `divreq_msg_a`, `divreq_msg_b`  out  32 each  registered operands.
- `divreq_val`  out  1  request valid.
- `divreq_rdy`  in  1  divider accepts the request.
- `divresp_msg_result`  in  64  {remainder, quotient}.
- `divresp_val`  in  1  response valid.
- `divresp_rdy`  out  1  block accepts the response.
- `wb_val`  out  1  writeback valid.
- `wb_rdy`  in  1  writeback consumer ready.
- `wb_data`  out  32  selected result.
- `wb_tag`  out  TAG_W  tag of the completing operation.
- `op_count`  out  32  number of completed writebacks. Wraps modulo 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - `op_rdy`=1.
  - On `op_val`, capture fn, a, b and tag into registers, then go to REQ.
- REQ:
  - `divreq_val`=1, with msg fields driven from registers, stable until the handshake.
  - On `divreq_rdy`, go to WAIT.
- WAIT:
  - `divresp_rdy`=1.
  - On `divresp_val`, capture into `res_reg`: `result[31:0]` when fn[1]=0, `result[63:32]` when fn[1]=1. Then go to WB.
- WB:
  - `wb_val`=1, `wb_data`=`res_reg`, `wb_tag`=`tag_reg`.
  - On `wb_rdy`, increment `op_count` and go to IDLE.
- Handshake ownership:
  - Only one handshake channel is active per state.
  - `op_rdy`, `divreq_val`, `divresp_rdy` and `wb_val` are decoded from state only, with no combinational paths from their partner signals.
  - They are never simultaneously high.
- A `divresp_val` outside WAIT is ignored (`divresp_rdy`=0).
- Signed-overflow (DIV 0x80000000 / -1) and other arithmetic corner results are produced by the divider and passed through unchanged.

## Timing
- Reset value of every output: `op_rdy`, `divreq_val`, `divresp_rdy`, `wb_val` = 0 while `reset` is high. `op_count`, `wb_data`, `wb_tag`, `divreq_msg_*` = 0.
- State after reset is IDLE. `op_rdy`=1 from the first edge after reset deasserts.
- Reset mid-operation (any state): asynchronous return to IDLE. The in-flight operation is discarded and `op_count` clears.
- Issuer overhead:
  - Op accept (edge N) to `divreq_val` (cycle N+1).
  - Response capture (edge M) to `wb_val` (cycle M+1).
- With the 32-iteration divider and no backpressure, `wb_val` asserts 35 cycles after the `op_val` handshake.
- Throughput: one operation in flight. The next accept happens in the cycle after the `wb_rdy` handshake.

## Configuration
- `IMULDIV_DIVZERO_BYPASS_EN`, when defined:
  - Accepting an op with `op_b`==0 goes IDLE→WB directly, with no divider request.
  - DIV/DIVU write 0xFFFFFFFF. REM/REMU write `op_a`.
  - `wb_val` asserts the cycle after the accept.
- When undefined: divide-by-zero is issued to the divider like any other op, and the divider's result is returned unchanged.

## Test plan
- DIV a=-7 (0xFFFFFFF9), b=2, tag=3 → one `divreq` with fn=1; `wb_data`=0xFFFFFFFD, `wb_tag`=3; `op_count`=1.
- REM -7/2 → 0xFFFFFFFF. REMU 100/7 → 2. DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF with `divreq_msg_fn`=0.
- Backpressure:
  - Hold `divreq_rdy`=0 for 5 cycles → `divreq_val` and msg fields stay stable.
  - Hold `wb_rdy`=0 for 4 cycles → `wb_val`, `wb_data` and `wb_tag` stay stable and `op_rdy` stays 0.
- DIVU 9/0:
  - With `IMULDIV_DIVZERO_BYPASS_EN` → `divreq_val` never asserts; `wb_data`=0xFFFFFFFF one cycle after the accept.
  - Without the macro → request is issued and the divider result is forwarded.
- Assert `reset` during WAIT → all valid/ready outputs drop immediately and `op_count`=0. A new op after reset completes correctly.
- Back-to-back ops with `op_val` held high → second accept occurs the cycle after the first `wb_rdy` handshake. `op_count` reaches 2.

Source files
------------

// File: rtl/imuldiv_int_div_issue.sv
// imuldiv_int_div_issue
// Issue front end for the iterative integer divider. It takes one
// DIV/DIVU/REM/REMU op at a time and sends it over the divreq channel. It
// then picks the quotient or remainder half of divresp and returns it with
// its tag on the writeback channel.
//
// Optional feature macro: IMULDIV_DIVZERO_BYPASS_EN
//   When defined, an op with op_b == 0 skips the divider. It goes straight
//   to writeback with the RISC-V divide-by-zero result.
//
// Handshake outputs are registered flags that move with the FSM. None of
// them depends combinationally on its partner signal.

module imuldiv_int_div_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             op_val,
    output logic             op_rdy,
    input  logic [1:0]       op_fn,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,

    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,

    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,

    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,

    output logic [31:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // Captured operation: fn[1] selects remainder, fn[0] selects unsigned.
    typedef struct packed {
        logic [1:0]       fn;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_req_t;

    // fn resets to DIVU so that divreq_msg_fn (= ~fn[0]) reads 0 in reset.
    localparam op_req_t OP_RESET = '{fn: 2'b01, a: '0, b: '0, tag: '0};

    state_t     state;
    op_req_t    op_q;
    logic [31:0] res_reg;
    logic        div_zero;
    logic [31:0] bypass_res;
    logic [31:0] resp_sel;

`ifdef IMULDIV_DIVZERO_BYPASS_EN
    assign div_zero = (op_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    // Divide-by-zero result: all ones for DIV/DIVU, the dividend for REM/REMU.
    assign bypass_res = op_fn[1] ? op_a : 32'hFFFF_FFFF;

    // Remainder lives in the upper half of the divider response.
    assign resp_sel = op_q.fn[1] ? divresp_msg_result[63:32]
                                 : divresp_msg_result[31:0];

    assign divreq_msg_fn = ~op_q.fn[0];
    assign divreq_msg_a  = op_q.a;
    assign divreq_msg_b  = op_q.b;
    assign wb_data       = res_reg;
    assign wb_tag        = op_q.tag;

    // Issue FSM: state, captured op, result and registered handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_RESET;
            res_reg     <= '0;
            op_count    <= '0;
            op_rdy      <= 1'b0;
            divreq_val  <= 1'b0;
            divresp_rdy <= 1'b0;
            wb_val      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // op_rdy is raised one cycle after reset release and
                    // stays up until an op is taken.
                    if (op_rdy && op_val) begin
                        op_q   <= '{fn: op_fn, a: op_a, b: op_b, tag: op_tag};
                        op_rdy <= 1'b0;
                        if (div_zero) begin
                            res_reg <= bypass_res;
                            wb_val  <= 1'b1;
                            state   <= WB;
                        end else begin
                            divreq_val <= 1'b1;
                            state      <= REQ;
                        end
                    end else begin
                        op_rdy <= 1'b1;
                    end
                end
                REQ: begin
                    if (divreq_rdy) begin
                        divreq_val  <= 1'b0;
                        divresp_rdy <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (divresp_val) begin
                        res_reg     <= resp_sel;
                        divresp_rdy <= 1'b0;
                        wb_val      <= 1'b1;
                        state       <= WB;
                    end
                end
                WB: begin
                    if (wb_rdy) begin
                        op_count <= op_count + 32'd1;
                        wb_val   <= 1'b0;
                        op_rdy   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    op_rdy      <= 1'b0;
                    divreq_val  <= 1'b0;
                    divresp_rdy <= 1'b0;
                    wb_val      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_int_div_issue.sv
// Testbench for imuldiv_int_div_issue.
// The bench models the divider as a responder with variable latency and
// RISC-V M semantics. A reference model predicts every writeback.

module tb_imuldiv_int_div_issue;

    localparam int TAG_W = 5;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]       fn;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_val, op_rdy;
    logic [1:0]       op_fn;
    logic [31:0]      op_a, op_b;
    logic [TAG_W-1:0] op_tag;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a, divreq_msg_b;
    logic             divreq_val, divreq_rdy;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val, divresp_rdy;
    logic             wb_val, wb_rdy;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      op_count;

    imuldiv_int_div_issue #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
        .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_tag(wb_tag),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Knobs shared by stimulus processes.
    bit rnd_en  = 1'b0;
    int req_stall = 0;
    int wb_stall  = 0;
    int lat_min = 3;
    int lat_max = 3;

    // Observations recorded by the monitor.
    int   req_cycles = 0;
    int   wb_cycles = 0;
    int   accept_cyc = 0;
    int   wb_fire_cyc = 0;
    int   wb_rise_cyc = 0;
    logic last_req_fn = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension result for one op.
    function automatic logic [31:0] ref_result(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Ready generators: a stall count holds rdy low for that many valid cycles.
    initial begin
        divreq_rdy = 1'b0;
        wb_rdy     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (divreq_val && req_stall > 0) begin
                divreq_rdy = 1'b0;
                req_stall--;
            end else divreq_rdy = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (wb_val && wb_stall > 0) begin
                wb_rdy = 1'b0;
                wb_stall--;
            end else wb_rdy = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Divider responder; it drives junk responses while idle, and the DUT must ignore them.
    initial begin
        logic        rf, sf, ds, dbusy;
        logic [31:0] da, db;
        int          dcnt;
        dbusy = 1'b0; dcnt = 0; ds = 1'b0; da = '0; db = '0;
        divresp_val = 1'b0;
        divresp_msg_result = '0;
        forever begin
            @(negedge clk);
            rf = divreq_val && divreq_rdy;
            sf = divresp_val && divresp_rdy;
            if (rf) begin
                da = divreq_msg_a; db = divreq_msg_b; ds = divreq_msg_fn;
            end
            @(posedge clk); #1;
            if (reset) begin
                dbusy = 1'b0;
                divresp_val = 1'b0;
            end else begin
                if (sf) begin
                    divresp_val = 1'b0;
                    dbusy = 1'b0;
                end
                if (rf) begin
                    dbusy = 1'b1;
                    dcnt = $urandom_range(lat_min, lat_max);
                    divresp_val = 1'b0;
                end else if (dbusy && !divresp_val && dcnt > 0) dcnt--;
                if (dbusy && !divresp_val && dcnt == 0) begin
                    divresp_val = 1'b1;
                    divresp_msg_result = {ref_result({1'b1, ~ds}, da, db), ref_result({1'b0, ~ds}, da, db)};
                end else if (!dbusy && !rf) begin
                    divresp_val = ($urandom_range(0, 7) == 0);
                    divresp_msg_result = {$urandom, $urandom};
                end
            end
        end
    end

    // Monitor: reference model of the op in flight, checked every cycle.
    initial begin
        op_t         cur;
        bit          have_op, prev_op_fire, prev_rsp_fire, prev_wb_fire, wb_seen;
        logic [31:0] exp_count;
        int          nh;
        cur = '0; have_op = 0; prev_op_fire = 0; prev_rsp_fire = 0; prev_wb_fire = 0; wb_seen = 0;
        exp_count = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_ctl", 64'({op_rdy, divreq_val, divresp_rdy, wb_val, divreq_msg_fn, wb_tag}), 64'd0);
                chk("rst_count", 64'(op_count), 64'd0);
                chk("rst_data", 64'(wb_data), 64'd0);
                chk("rst_msg", {divreq_msg_a, divreq_msg_b}, 64'd0);
                have_op = 0; exp_count = '0;
                prev_op_fire = 0; prev_rsp_fire = 0; prev_wb_fire = 0;
                continue;
            end
            nh = int'(op_rdy) + int'(divreq_val) + int'(divresp_rdy) + int'(wb_val);
            chk("one_channel", 64'(nh > 1), 64'd0);
            chk("op_count", 64'(op_count), 64'(exp_count));
            if (prev_op_fire) begin
                if (BYP && cur.b == 0) chk("bypass_wb_lat", 64'(wb_val), 64'd1);
                else chk("req_lat", 64'(divreq_val), 64'd1);
            end
            if (prev_rsp_fire) chk("wb_lat", 64'(wb_val), 64'd1);
            if (prev_wb_fire) chk("op_rdy_after_wb", 64'(op_rdy), 64'd1);
            if (divreq_val) begin
                req_cycles++;
                chk("req_pending", 64'(have_op), 64'd1);
                chk("req_a", 64'(divreq_msg_a), 64'(cur.a));
                chk("req_b", 64'(divreq_msg_b), 64'(cur.b));
                chk("req_fn", 64'(divreq_msg_fn), 64'(!cur.fn[0]));
                if (BYP) chk("req_b_nonzero", 64'(cur.b == 0), 64'd0);
            end
            if (wb_val) begin
                wb_cycles++;
                chk("wb_pending", 64'(have_op), 64'd1);
                chk("wb_data", 64'(wb_data), 64'(ref_result(cur.fn, cur.a, cur.b)));
                chk("wb_tag", 64'(wb_tag), 64'(cur.tag));
                if (!wb_seen) begin
                    wb_rise_cyc = cyc;
                    wb_seen = 1;
                end
            end
            prev_op_fire  = op_val && op_rdy;
            prev_rsp_fire = divresp_val && divresp_rdy;
            prev_wb_fire  = wb_val && wb_rdy;
            if (divreq_val && divreq_rdy) last_req_fn = divreq_msg_fn;
            if (prev_wb_fire) begin
                exp_count = exp_count + 32'd1;
                have_op = 0;
                wb_fire_cyc = cyc;
            end
            if (prev_op_fire) begin
                cur = '{fn: op_fn, a: op_a, b: op_b, tag: op_tag};
                have_op = 1;
                accept_cyc = cyc;
                req_cycles = 0;
                wb_cycles = 0;
                wb_seen = 0;
            end
        end
    end

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (op_val && op_rdy) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 64'(!ok), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (op_rdy) break;
        end
        chk("drain_timeout", 64'(op_rdy), 64'd1);
        @(posedge clk); #1;
    endtask

    // One directed op, with the writeback checked against a literal expectation.
    task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp, input string nm);
        bit got;
        @(posedge clk); #1;
        op_fn = fn; op_a = a; op_b = b; op_tag = tag; op_val = 1'b1;
        wait_accept();
        op_val = 1'b0;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wb_val) begin
                got = 1;
                break;
            end
        end
        chk({nm, "_wb_timeout"}, 64'(!got), 64'd0);
        if (got) begin
            chk(nm, 64'(wb_data), 64'(exp));
            chk({nm, "_tag"}, 64'(wb_tag), 64'(tag));
        end
        for (int i = 0; i < 300; i++) begin
            if (wb_val && wb_rdy) break;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_word(input bit is_b);
        case ($urandom_range(0, 7))
            0:       return is_b ? 32'd0 : 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2, 3:    return $urandom_range(1, 40);
            4:       return -$urandom_range(1, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op_val = 1'b0; op_fn = '0; op_a = '0; op_b = '0; op_tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_op_rdy", 64'(op_rdy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("op_rdy_before_edge", 64'(op_rdy), 64'd0);
        @(negedge clk);
        chk("op_rdy_after_edge", 64'(op_rdy), 64'd1);

        // Pin the reference model with values worked by hand.
        chk("model_div", 64'(ref_result(2'b00, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        chk("model_rem", 64'(ref_result(2'b10, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
        chk("model_remu", 64'(ref_result(2'b11, 32'd100, 32'd7)), 64'd2);
        chk("model_ovf", 64'(ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);

        // Directed ops, with no random backpressure.
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, "div_m7_2");
        chk("div_req_fn", 64'(last_req_fn), 64'd1);
        chk("count_1", 64'(op_count), 64'd1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(2'b11, 32'd100, 32'd7, 5'd5, 32'd2, "remu_100_7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd6, 32'h0FFF_FFFF, "divu_ffff_16");
        chk("divu_req_fn", 64'(last_req_fn), 64'd0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, "div_ovf");

        // Backpressure on both channels.
        req_stall = 5; wb_stall = 4;
        run_op(2'b11, 32'd1000, 32'd33, 5'd9, 32'd10, "remu_stall");
        chk("req_hold_cycles", 64'(req_cycles), 64'd6);
        chk("wb_hold_cycles", 64'(wb_cycles), 64'd5);

        // Divide by zero: bypass or pass through the divider.
        run_op(2'b01, 32'd9, 32'd0, 5'd10, 32'hFFFF_FFFF, "divu_9_0");
        chk("div0_req_cycles", 64'(req_cycles), BYP ? 64'd0 : 64'd1);
        run_op(2'b11, 32'd9, 32'd0, 5'd11, 32'd9, "remu_9_0");

        // End-to-end latency with a 32-cycle divider.
        lat_min = 32; lat_max = 32;
        run_op(2'b00, 32'd1000, 32'd3, 5'd12, 32'd333, "div_lat32");
        chk("lat_35", 64'(wb_rise_cyc - accept_cyc), 64'd35);

        // Reset while waiting on the divider.
        lat_min = 20; lat_max = 20;
        @(posedge clk); #1;
        op_fn = 2'b00; op_a = 32'd50; op_b = 32'd5; op_tag = 5'd13; op_val = 1'b1;
        wait_accept();
        op_val = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (divresp_rdy) break;
        end
        chk("reached_wait", 64'(divresp_rdy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ctl", 64'({op_rdy, divreq_val, divresp_rdy, wb_val}), 64'd0);
        chk("async_rst_count", 64'(op_count), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        lat_min = 3; lat_max = 3;
        run_op(2'b01, 32'd50, 32'd5, 5'd14, 32'd10, "after_reset");
        chk("count_after_reset", 64'(op_count), 64'd1);

        // Back-to-back ops, with op_val held high.
        lat_min = 2; lat_max = 2;
        @(posedge clk); #1;
        op_fn = 2'b00; op_a = 32'd20; op_b = 32'd4; op_tag = 5'd1; op_val = 1'b1;
        wait_accept();
        op_fn = 2'b10; op_a = 32'd20; op_b = 32'd6; op_tag = 5'd2;
        wait_accept();
        chk("b2b_gap", 64'(accept_cyc - wb_fire_cyc), 64'd1);
        op_val = 1'b0;
        wait_idle();
        chk("b2b_count", 64'(op_count), 64'd3);

        // Randomized traffic with random backpressure and latency.
        rnd_en = 1'b1; lat_min = 0; lat_max = 6;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            op_fn  = 2'($urandom_range(0, 3));
            op_a   = rnd_word(1'b0);
            op_b   = rnd_word(1'b1);
            op_tag = TAG_W'($urandom);
            op_val = 1'b1;
            wait_accept();
            op_val = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
